// File: rtl/mips_regfile_writeback.sv
// Write-side sequencer for the 32x32 MIPS register file: FIFO-buffered writes drained one per cycle.
// Define WB_FORWARD_EN to build the pending-write forwarding lookup; otherwise fwd_hit/fwd_data are tied to 0.
module mips_regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_dest,
  input  logic [31:0]            in_data,
  input  logic                   drain_hold,
  output logic                   wb_load_enable,
  output logic [4:0]             wb_dest_select,
  output logic [31:0]            wb_reg_data,
  input  logic [4:0]             fwd_sel,
  output logic                   fwd_hit,
  output logic [31:0]            fwd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_le_q, wb_le_d;
  logic [4:0]    wb_dest_q, wb_dest_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          accept;
  logic          push;
  logic          pop;

  // Writes to r0 are acknowledged but never queued.
  assign in_ready = reset && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_dest != 5'd0);
  assign pop      = (count_q != '0) && !drain_hold;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wb_le_d   = pop;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wb_dest_d = dest_mem[rd_ptr_q];
      wb_data_d = data_mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_le_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_le_q   <= wb_le_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes only from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_q] <= in_dest;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  assign wb_load_enable = wb_le_q;
  assign wb_dest_select = wb_dest_q;
  assign wb_reg_data    = wb_data_q;
  assign count          = count_q;

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest match wins; the wb stage ranks below every FIFO entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_sel != 5'd0) begin
      if (wb_le_q && (wb_dest_q == fwd_sel)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) && (dest_mem[rd_ptr_q + PW'(i)] == fwd_sel)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[rd_ptr_q + PW'(i)];
        end
      end
    end
  end
`else
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^fwd_sel;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule
